mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, transfer cycles without mem ready before bus error.
REQ-002 Parameter: ERR_RDATA, 32'h0000_0000, read data returned on a timed-out read.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 if_req  input  1  fetch read request, level, held until if_ready.
REQ-006 if_addr  input  32  fetch address.
REQ-007 if_rdata  output  32  fetch read data, valid with if_ready.
REQ-008 if_ready  output  1  one-cycle fetch completion pulse.
REQ-009 ls_read_en / ls_write_en  input  1 each  load/store requests, level, held until matching ready.
REQ-010 ls_addr, ls_wdata  input  32 each  load/store address and store data.
REQ-011 ls_byte_size  input  2  0 = 32-bit, 1 = 8-bit, 2 = 16-bit.
REQ-012 ls_rdata  output  32  load data; ls_read_ready, ls_write_ready  output  1 each  one-cycle completion pulses.
REQ-013 mem_read_en, mem_write_en  output  1 each; mem_addr, mem_data  output  32 each; mem_byte_size  output  2  shared memory port.
REQ-014 mem_data_in  input  32; mem_read_ready, mem_write_ready  input  1 each  memory responses.
REQ-015 grant  output  2  current owner: 0 none, 1 fetch, 2 load/store.
REQ-016 bus_err  output  1  one-cycle pulse on transfer timeout.

Function
REQ-017 States: IDLE, IF_XFER, LS_XFER, RELEASE; all mem_* and requester outputs registered.
REQ-018 IDLE, single requester active: latch its addr/data/size into mem_*, assert mem_read_en or mem_write_en, enter its XFER state; enable is visible the cycle after the request is first sampled.
REQ-019 IDLE, both active: round-robin; grant the requester not granted last; last_grant resets to fetch, so load/store wins the first tie.
REQ-020 Fetch grants drive mem_byte_size = 0 and mem_read_en only.
REQ-021 ls_read_en and ls_write_en both high: write served, read ignored until re-presented.
REQ-022 XFER: mem_* held stable; requester input changes ignored until completion.
REQ-023 On mem_read_ready (read) or mem_write_ready (write) in XFER: capture mem_data_in into the owner's rdata for reads, pulse the owner's ready for one cycle, drop mem enables, enter RELEASE.
REQ-024 RELEASE: one cycle, mem enables low, grant = 0, requests not sampled; then IDLE. Back-to-back same-requester transfers are 1 idle + 1 sample cycle apart.
REQ-025 Timeout counter clears on grant and increments each XFER cycle without ready; on reaching TIMEOUT_CYCLES, pulse bus_err and the owner's ready, return ERR_RDATA for reads, drop enables, enter RELEASE.
REQ-026 Ready and timeout in the same cycle: normal completion, no bus_err.
REQ-027 mem_read_ready/mem_write_ready in IDLE or RELEASE, or of the wrong kind for the current transfer: ignored.
REQ-028 No alignment checking; mem_addr passes unmodified.

Reset
REQ-029 rst low: state = IDLE, last_grant = fetch, counter = 0, all outputs 0, asynchronously.
REQ-030 Reset during XFER aborts without any ready pulse or bus_err; requesters re-present after reset.

Structure
REQ-031 Shared package (config.v): byte_size encodings, state encodings, grant encodings.
REQ-032 One sub-module, mem_arb_rr2: combinational two-way round-robin picker (req[1:0], last_grant -> pick); the counter and FSM stay in mem_bus_arbiter.
REQ-033 Counter width $clog2(TIMEOUT_CYCLES+1).

Verification
REQ-034 Fetch-only read at 0x100; memory returns 0xDEADBEEF after 3 cycles -> mem_read_en high 1 cycle after request, if_rdata = 0xDEADBEEF, if_ready pulses once, grant 1 then 0.
REQ-035 Fetch and load simultaneous from reset -> load/store served first; fetch served after RELEASE; a second simultaneous pair -> fetch first.
REQ-036 ls_write_en, addr 0x2000, wdata 0x12345678, size 2 -> mem_byte_size = 2, mem_data = 0x12345678, ls_write_ready pulses on mem_write_ready.
REQ-037 Load with no memory response, TIMEOUT_CYCLES = 4 -> bus_err and ls_read_ready pulse together after 4 XFER cycles, ls_rdata = ERR_RDATA.
REQ-038 rst asserted mid LS_XFER -> all outputs 0 immediately, no ready pulse; a request after release -> normal transfer.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the two-requester memory bus arbiter: byte sizes,
// FSM states, grant owners and the registered output bundle.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        BS_WORD = 2'd0,
        BS_BYTE = 2'd1,
        BS_HALF = 2'd2
    } byte_size_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_XFER = 2'd1,
        ST_LS_XFER = 2'd2,
        ST_RELEASE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_IF   = 2'd1,
        GRANT_LS   = 2'd2
    } grant_e;

    // Every requester-facing and memory-facing output comes from one of these registers.
    typedef struct packed {
        logic [31:0] if_rdata;
        logic        if_ready;
        logic [31:0] ls_rdata;
        logic        ls_read_ready;
        logic        ls_write_ready;
        logic        mem_read_en;
        logic        mem_write_en;
        logic [31:0] mem_addr;
        logic [31:0] mem_data;
        logic [1:0]  mem_byte_size;
        logic [1:0]  grant;
        logic        bus_err;
    } arb_out_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the fetch/load-store requesters, the arbiter and memory.
// slave = arbiter view, master = requester/memory environment view.
interface mem_bus_arbiter_if;
    // Handshake: requests (if_req, ls_read_en, ls_write_en) are levels held until
    // the matching one-cycle *_ready pulse; memory likewise answers a held enable
    // with a one-cycle mem_read_ready/mem_write_ready.
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        ls_read_en;
    logic        ls_write_en;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [1:0]  ls_byte_size;
    logic [31:0] ls_rdata;
    logic        ls_read_ready;
    logic        ls_write_ready;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [1:0]  mem_byte_size;
    logic [31:0] mem_data_in;
    logic        mem_read_ready;
    logic        mem_write_ready;
    logic [1:0]  grant;
    logic        bus_err;

    modport slave (
        input  if_req, if_addr, ls_read_en, ls_write_en, ls_addr, ls_wdata, ls_byte_size,
        input  mem_data_in, mem_read_ready, mem_write_ready,
        output if_rdata, if_ready, ls_rdata, ls_read_ready, ls_write_ready,
        output mem_read_en, mem_write_en, mem_addr, mem_data, mem_byte_size,
        output grant, bus_err
    );

    modport master (
        output if_req, if_addr, ls_read_en, ls_write_en, ls_addr, ls_wdata, ls_byte_size,
        output mem_data_in, mem_read_ready, mem_write_ready,
        input  if_rdata, if_ready, ls_rdata, ls_read_ready, ls_write_ready,
        input  mem_read_en, mem_write_en, mem_addr, mem_data, mem_byte_size,
        input  grant, bus_err
    );
endinterface

// File: rtl/mem_bus_arbiter_rr2.sv
// Combinational two-way round-robin picker: bit 0 = fetch, bit 1 = load/store.
module mem_arb_rr2
    import mem_bus_arbiter_pkg::*;
(
    input  logic [1:0] i_req,
    input  grant_e     i_last_grant,
    output grant_e     o_pick
);

    always_comb begin
        o_pick = GRANT_NONE;
        case (i_req)
            2'b01:   o_pick = GRANT_IF;
            2'b10:   o_pick = GRANT_LS;
            2'b11:   o_pick = (i_last_grant == GRANT_IF) ? GRANT_LS : GRANT_IF;
            default: o_pick = GRANT_NONE;
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one shared memory port between instruction fetch and load/store,
// with round-robin tie breaking, a per-transfer timeout and a release cycle.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    mem_bus_arbiter_if.slave bus,
    output state_e           o_dbg_state
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e           r_state, w_state_nxt;
    grant_e           r_last_grant, w_last_nxt, w_pick;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    arb_out_t         r_out, w_nxt;
    logic [1:0]       w_req;
    logic             w_done, w_timeout;
    logic [31:0]      w_rd_data;

    assign w_req     = {bus.ls_read_en | bus.ls_write_en, bus.if_req};
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_timeout = (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES));
    // Only the response matching the transfer direction completes it.
    assign w_done    = r_out.mem_write_en ? bus.mem_write_ready : bus.mem_read_ready;
    assign w_rd_data = w_done ? bus.mem_data_in : ERR_RDATA;

    mem_arb_rr2 u_rr2 (
        .i_req        (w_req),
        .i_last_grant (r_last_grant),
        .o_pick       (w_pick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= GRANT_IF;
            r_cnt        <= '0;
            r_out        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_nxt;
            r_cnt        <= w_cnt_nxt;
            r_out        <= w_nxt;
        end
    end

    always_comb begin
        w_nxt                = r_out;
        w_nxt.if_ready       = 1'b0;
        w_nxt.ls_read_ready  = 1'b0;
        w_nxt.ls_write_ready = 1'b0;
        w_nxt.bus_err        = 1'b0;
        w_state_nxt          = r_state;
        w_last_nxt           = r_last_grant;
        w_cnt_nxt            = r_cnt;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (w_pick == GRANT_IF) begin
                    w_nxt.mem_read_en   = 1'b1;
                    w_nxt.mem_write_en  = 1'b0;
                    w_nxt.mem_addr      = bus.if_addr;
                    w_nxt.mem_data      = '0;
                    w_nxt.mem_byte_size = BS_WORD;
                    w_nxt.grant         = GRANT_IF;
                    w_last_nxt          = GRANT_IF;
                    w_state_nxt         = ST_IF_XFER;
                end else if (w_pick == GRANT_LS) begin
                    // A write wins over a simultaneous read; the read must be re-presented.
                    w_nxt.mem_read_en   = ~bus.ls_write_en;
                    w_nxt.mem_write_en  = bus.ls_write_en;
                    w_nxt.mem_addr      = bus.ls_addr;
                    w_nxt.mem_data      = bus.ls_wdata;
                    w_nxt.mem_byte_size = bus.ls_byte_size;
                    w_nxt.grant         = GRANT_LS;
                    w_last_nxt          = GRANT_LS;
                    w_state_nxt         = ST_LS_XFER;
                end
            end
            ST_IF_XFER, ST_LS_XFER: begin
                if (w_done || w_timeout) begin
                    if (r_state == ST_IF_XFER) begin
                        w_nxt.if_rdata = w_rd_data;
                        w_nxt.if_ready = 1'b1;
                    end else if (r_out.mem_write_en) begin
                        w_nxt.ls_write_ready = 1'b1;
                    end else begin
                        w_nxt.ls_rdata      = w_rd_data;
                        w_nxt.ls_read_ready = 1'b1;
                    end
                    w_nxt.bus_err      = ~w_done;
                    w_nxt.mem_read_en  = 1'b0;
                    w_nxt.mem_write_en = 1'b0;
                    w_nxt.grant        = GRANT_NONE;
                    w_state_nxt        = ST_RELEASE;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            ST_RELEASE: w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    assign bus.if_rdata       = r_out.if_rdata;
    assign bus.if_ready       = r_out.if_ready;
    assign bus.ls_rdata       = r_out.ls_rdata;
    assign bus.ls_read_ready  = r_out.ls_read_ready;
    assign bus.ls_write_ready = r_out.ls_write_ready;
    assign bus.mem_read_en    = r_out.mem_read_en;
    assign bus.mem_write_en   = r_out.mem_write_en;
    assign bus.mem_addr       = r_out.mem_addr;
    assign bus.mem_data       = r_out.mem_data;
    assign bus.mem_byte_size  = r_out.mem_byte_size;
    assign bus.grant          = r_out.grant;
    assign bus.bus_err        = r_out.bus_err;
    assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a table of single transfers plus
// hand-written round-robin, idle-response, timeout and mid-transfer reset sequences.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam logic [31:0] TB_ERR = 32'hE77E_0000;
  localparam logic [1:0] K_FETCH = 2'd0;
  localparam logic [1:0] K_LOAD  = 2'd1;
  localparam logic [1:0] K_STORE = 2'd2;
  localparam logic [1:0] K_BOTH  = 2'd3;

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    int          lat;
    logic [31:0] mem_rd;
    logic [1:0]  exp_grant;
    logic [1:0]  exp_en;     // {write, read}
    logic [1:0]  exp_size;
    logic [31:0] exp_data;
    logic [31:0] exp_rdata;
    logic [2:0]  exp_rdy;    // {if_ready, ls_read_ready, ls_write_ready}
  } vec_t;

  logic   clk;
  logic   rst;
  state_e dbg_state;
  int     checks;
  int     failures;
  vec_t   vecs[7];
  vec_t   post_rst_vec;
  logic [31:0] exp_q[$];

  mem_bus_arbiter_if b();

  mem_bus_arbiter #(
    .TIMEOUT_CYCLES (4),
    .ERR_RDATA      (TB_ERR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (b),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctrl"}, 32'({b.mem_read_en, b.mem_write_en, b.mem_byte_size, b.if_ready,
                             b.ls_read_ready, b.ls_write_ready, b.grant, b.bus_err}), 32'd0);
    chk({tag, "_mem_addr"}, b.mem_addr, 32'd0);
    chk({tag, "_mem_data"}, b.mem_data, 32'd0);
    chk({tag, "_if_rdata"}, b.if_rdata, 32'd0);
    chk({tag, "_ls_rdata"}, b.ls_rdata, 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  task automatic clear_inputs();
    b.if_req = 1'b0; b.if_addr = '0;
    b.ls_read_en = 1'b0; b.ls_write_en = 1'b0;
    b.ls_addr = '0; b.ls_wdata = '0; b.ls_byte_size = '0;
    b.mem_data_in = '0; b.mem_read_ready = 1'b0; b.mem_write_ready = 1'b0;
  endtask

  // driver: one complete transfer from a single requester, checked at every step
  task automatic run_xfer(input vec_t v, input string tag);
    b.if_req      = (v.kind == K_FETCH);
    b.ls_read_en  = (v.kind == K_LOAD) || (v.kind == K_BOTH);
    b.ls_write_en = (v.kind == K_STORE) || (v.kind == K_BOTH);
    b.if_addr = v.addr; b.ls_addr = v.addr; b.ls_wdata = v.wdata; b.ls_byte_size = v.size;
    tick();
    chk({tag, "_grant"}, 32'(b.grant), 32'(v.exp_grant));
    chk({tag, "_en"}, 32'({b.mem_write_en, b.mem_read_en}), 32'(v.exp_en));
    chk({tag, "_addr"}, b.mem_addr, v.addr);
    chk({tag, "_size"}, 32'(b.mem_byte_size), 32'(v.exp_size));
    if (v.exp_en[1]) chk({tag, "_wdata"}, b.mem_data, v.exp_data);
    // scramble requester inputs and offer the wrong-kind response while waiting
    b.if_addr = ~v.addr; b.ls_addr = ~v.addr; b.ls_wdata = ~v.wdata; b.ls_byte_size = ~v.size;
    b.mem_data_in = 32'h5A5A_5A5A;
    for (int i = 0; i < v.lat; i++) begin
      b.mem_read_ready  = v.exp_en[1];
      b.mem_write_ready = v.exp_en[0];
      tick();
      chk({tag, "_hold"}, 32'({b.grant, b.mem_write_en, b.mem_read_en, b.mem_byte_size,
                               b.if_ready, b.ls_read_ready, b.ls_write_ready}),
          32'({v.exp_grant, v.exp_en, v.exp_size, 3'b000}));
      chk({tag, "_hold_addr"}, b.mem_addr, v.addr);
    end
    b.mem_read_ready  = v.exp_en[0];
    b.mem_write_ready = v.exp_en[1];
    b.mem_data_in     = v.mem_rd;
    tick();
    chk({tag, "_ready"}, 32'({b.if_ready, b.ls_read_ready, b.ls_write_ready}), 32'(v.exp_rdy));
    chk({tag, "_done"}, 32'({b.grant, b.mem_write_en, b.mem_read_en, b.bus_err}), 32'd0);
    if (v.exp_rdy[2]) chk({tag, "_if_rdata"}, b.if_rdata, v.exp_rdata);
    else              chk({tag, "_ls_rdata"}, b.ls_rdata, v.exp_rdata);
    clear_inputs();
    tick();
    chk({tag, "_after"}, 32'({b.if_ready, b.ls_read_ready, b.ls_write_ready, b.grant}), 32'd0);
    chk({tag, "_idle"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // scoreboard: expected read data in completion order for the round-robin sequence
  task automatic sb_check(input string name, input logic [31:0] act);
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s: got %h expected <empty queue>", name, act);
    end else begin
      chk(name, act, exp_q.pop_front());
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    //          kind     addr           wdata         sz lat mem_rd         gnt en     sz    exp_data      exp_rdata      rdy
    vecs[0] = '{K_FETCH, 32'h0000_0100, 32'h0,        2, 2, 32'hDEAD_BEEF, 1, 2'b01, 2'd0, 32'h0,        32'hDEAD_BEEF, 3'b100};
    vecs[1] = '{K_LOAD,  32'h0000_3004, 32'h0,        1, 0, 32'hCAFE_F00D, 2, 2'b01, 2'd1, 32'h0,        32'hCAFE_F00D, 3'b010};
    vecs[2] = '{K_STORE, 32'h0000_2000, 32'h1234_5678, 2, 1, 32'hFFFF_0000, 2, 2'b10, 2'd2, 32'h1234_5678, 32'hCAFE_F00D, 3'b001};
    vecs[3] = '{K_FETCH, 32'h0000_0FFE, 32'h0,        1, 3, 32'h0BAD_CAFE, 1, 2'b01, 2'd0, 32'h0,        32'h0BAD_CAFE, 3'b100};
    vecs[4] = '{K_LOAD,  32'hFFFF_FFFC, 32'h0,        0, 3, 32'h8000_0001, 2, 2'b01, 2'd0, 32'h0,        32'h8000_0001, 3'b010};
    vecs[5] = '{K_BOTH,  32'h0000_0013, 32'h0000_00A5, 1, 1, 32'h7777_7777, 2, 2'b10, 2'd1, 32'h0000_00A5, 32'h8000_0001, 3'b001};
    vecs[6] = '{K_STORE, 32'h0000_0004, 32'h0000_BEEF, 2, 0, 32'h0,        2, 2'b10, 2'd2, 32'h0000_BEEF, 32'h8000_0001, 3'b001};
    post_rst_vec = '{K_LOAD, 32'h0000_8004, 32'h0, 2, 1, 32'h600D_D00D, 2, 2'b01, 2'd2, 32'h0, 32'h600D_D00D, 3'b010};

    clear_inputs();
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    #2 rst = 1'b1;
    tick();

    // round robin: tie from reset goes to load/store, then fetch, then the re-presented load
    exp_q.push_back(32'h1111_0001);
    exp_q.push_back(32'h2222_0002);
    exp_q.push_back(32'h3333_0003);
    b.if_req = 1'b1; b.if_addr = 32'h0000_0400;
    b.ls_read_en = 1'b1; b.ls_addr = 32'h0000_0500;
    tick();
    chk("rr1_grant", 32'(b.grant), 32'd2);
    chk("rr1_addr", b.mem_addr, 32'h0000_0500);
    b.mem_read_ready = 1'b1; b.mem_data_in = 32'h1111_0001;
    tick();
    chk("rr1_done", 32'({b.ls_read_ready, b.if_ready, b.grant, b.mem_read_en}), 32'b10000);
    sb_check("rr1_rdata", b.ls_rdata);
    b.mem_read_ready = 1'b0; b.ls_addr = 32'h0000_0600;
    tick();
    chk("rr_release_gap", 32'({b.mem_read_en, b.grant, b.ls_read_ready, b.if_ready}), 32'd0);
    tick();
    chk("rr2_grant", 32'(b.grant), 32'd1);
    chk("rr2_addr", b.mem_addr, 32'h0000_0400);
    b.mem_read_ready = 1'b1; b.mem_data_in = 32'h2222_0002;
    tick();
    chk("rr2_done", 32'({b.if_ready, b.ls_read_ready, b.grant}), 32'b1000);
    sb_check("rr2_rdata", b.if_rdata);
    b.mem_read_ready = 1'b0; b.if_req = 1'b0;
    tick();
    tick();
    chk("rr3_grant", 32'(b.grant), 32'd2);
    chk("rr3_addr", b.mem_addr, 32'h0000_0600);
    b.mem_read_ready = 1'b1; b.mem_data_in = 32'h3333_0003;
    tick();
    chk("rr3_done", 32'(b.ls_read_ready), 32'd1);
    sb_check("rr3_rdata", b.ls_rdata);
    clear_inputs();
    tick();
    chk("rr_queue_drained", 32'(exp_q.size()), 32'd0);

    // table of single-requester transfers
    for (int i = 0; i < 7; i++) run_xfer(vecs[i], $sformatf("vec%0d", i));

    // memory responses with nothing granted are ignored
    b.mem_read_ready = 1'b1; b.mem_write_ready = 1'b1; b.mem_data_in = 32'hFEED_FACE;
    repeat (2) begin
      tick();
      chk("idle_resp_ctrl", 32'({b.if_ready, b.ls_read_ready, b.ls_write_ready, b.grant,
                                 b.mem_read_en, b.mem_write_en, b.bus_err}), 32'd0);
    end
    chk("idle_resp_if_rdata", b.if_rdata, 32'h0BAD_CAFE);
    chk("idle_resp_ls_rdata", b.ls_rdata, 32'h8000_0001);
    clear_inputs();
    tick();

    // load with no memory response times out after 4 transfer cycles
    b.ls_read_en = 1'b1; b.ls_addr = 32'h0000_7000; b.ls_byte_size = 2'd0;
    tick();
    chk("to_grant", 32'({b.grant, b.mem_read_en}), 32'b101);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to_wait", 32'({b.mem_read_en, b.bus_err, b.ls_read_ready}), 32'b100);
    end
    tick();
    chk("to_pulse", 32'({b.bus_err, b.ls_read_ready, b.mem_read_en, b.grant}), 32'b11000);
    chk("to_rdata", b.ls_rdata, TB_ERR);
    clear_inputs();
    tick();
    chk("to_pulse_end", 32'({b.bus_err, b.ls_read_ready}), 32'd0);

    // reset in the middle of a store aborts it silently
    b.ls_write_en = 1'b1; b.ls_addr = 32'h0000_8000; b.ls_wdata = 32'h0000_0055;
    tick();
    chk("mr_grant", 32'({b.grant, b.mem_write_en}), 32'b101);
    tick();
    #2;
    b.mem_write_ready = 1'b1;
    rst = 1'b0;
    #1;
    chk_zero("midrst");
    tick();
    chk("midrst_held", 32'({b.ls_write_ready, b.bus_err, b.mem_write_en, b.grant}), 32'd0);
    clear_inputs();
    #2 rst = 1'b1;
    tick();
    run_xfer(post_rst_vec, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
